// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU: one quotient bit per cycle,
// fixed latency of WIDTH+1 cycles from the accepting edge to the done pulse.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             is_rem_q, is_rem_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             div0_q, div0_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   rem_shift;
  logic             ge;
  logic [WIDTH-1:0] rem_step, quo_step;
  logic [WIDTH-1:0] q_fix, r_fix;

  // Signed ops take magnitudes; the WIDTH-bit negation maps -2^(WIDTH-1) onto itself.
  always_comb begin
    a_neg = ~op[0] & src_a[WIDTH-1];
    b_neg = ~op[0] & src_b[WIDTH-1];
    a_mag = a_neg ? (~src_a + 1'b1) : src_a;
    b_mag = b_neg ? (~src_b + 1'b1) : src_b;
  end

  always_comb begin
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    ge        = (rem_shift >= {1'b0, dvs_q});
    rem_step  = ge ? (rem_shift[WIDTH-1:0] - dvs_q) : rem_shift[WIDTH-1:0];
    quo_step  = {quo_q[WIDTH-2:0], ge};
    // Divide-by-zero quotient is forced to all-ones instead of being sign-corrected.
    q_fix     = div0_q ? {WIDTH{1'b1}} : (q_neg_q ? (~quo_step + 1'b1) : quo_step);
    r_fix     = r_neg_q ? (~rem_step + 1'b1) : rem_step;
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    result_d = result_q;
    is_rem_d = is_rem_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    div0_d   = div0_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          is_rem_d = op[1];
          q_neg_d  = a_neg ^ b_neg;
          r_neg_d  = a_neg;
          div0_d   = (src_b == '0);
          quo_d    = a_mag;
          dvs_d    = b_mag;
          rem_d    = '0;
          count_d  = CW'(WIDTH);
          state_d  = CALC;
        end
      end
      CALC: begin
        rem_d   = rem_step;
        quo_d   = quo_step;
        count_d = count_q - 1'b1;
        if (count_q == CW'(1)) begin
          result_d = is_rem_q ? r_fix : q_fix;
          state_d  = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
      is_rem_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      result_q <= result_d;
      is_rem_q <= is_rem_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      div0_q   <= div0_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == FIN);
  assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: a latency/arithmetic reference model checked
// every cycle, plus directed vectors with hand-computed results.
module tb_div_unit;

  localparam int W = 32;
  localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         busy, done;
  logic [W-1:0] result;

  int n_cmp = 0;
  int n_fail = 0;

  div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the RV32M rules.
  function automatic logic [W-1:0] ref_fn(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] minv;
    minv = {1'b1, {(W-1){1'b0}}};
    if (b == '0) return o[1] ? a : {W{1'b1}};
    case (o)
      DIV:  return (a == minv && b == {W{1'b1}}) ? minv : W'($signed(a) / $signed(b));
      REM:  return (a == minv && b == {W{1'b1}}) ? '0   : W'($signed(a) % $signed(b));
      DIVU: return a / b;
      default: return a % b;
    endcase
  endfunction

  // Model: an accepted start leads to W+1 busy cycles, the last one carrying done
  // and the new result; starts are only honoured when nothing is in flight.
  int           m_cnt;
  logic [W-1:0] m_pend, m_res;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt  <= 0;
      m_res  <= '0;
      m_pend <= '0;
    end else if (m_cnt == 0) begin
      if (start) begin
        m_cnt  <= W + 1;
        m_pend <= ref_fn(op, src_a, src_b);
      end
    end else begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 2) m_res <= m_pend;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("busy", W'(busy), W'(m_cnt > 0));
      check("done", W'(done), W'(m_cnt == 1));
      check("result", result, m_res);
    end
  end

  // Issue one op, scramble the inputs afterwards, and time the done pulse.
  task automatic run(input string name, input logic [1:0] o, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [W-1:0] exp);
    int n;
    @(negedge clk);
    op = o; src_a = a; src_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); src_a = $urandom; src_b = $urandom;
    n = 1;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({name, " latency"}, W'(n), W'(33));
    check(name, result, exp);
    $display("%-18s op=%0d a=0x%08h b=0x%08h -> 0x%08h (exp 0x%08h) after %0d cycles",
             name, o, a, b, result, exp, n);
  endtask

  initial begin
    int n, pulses;

    // Pin the reference function with hand-computed values.
    check("model divu", ref_fn(DIVU, 32'd100, 32'd7), 32'd14);
    check("model div", ref_fn(DIV, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    check("model rem", ref_fn(REM, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    check("model ovf", ref_fn(DIV, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
    check("model rem0", ref_fn(REM, 32'hFFFF_FFFB, 32'd0), 32'hFFFF_FFFB);

    #12;
    check("reset busy", W'(busy), '0);
    check("reset done", W'(done), '0);
    check("reset result", result, '0);
    @(negedge clk);
    rst_n = 1'b1;

    run("divu 100/7", DIVU, 32'd100, 32'd7, 32'd14);
    run("remu 100/7", REMU, 32'd100, 32'd7, 32'd2);
    run("div -7/2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run("rem -7/2", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run("div 7/-2", DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
    run("rem 7/-2", REM, 32'd7, 32'hFFFF_FFFE, 32'd1);
    run("div 5/0", DIV, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run("divu beef/0", DIVU, 32'hDEAD_BEEF, 32'd0, 32'hFFFF_FFFF);
    run("rem -5/0", REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB);
    run("remu 9/0", REMU, 32'd9, 32'd0, 32'd9);
    run("div ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run("rem ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    run("divu max/1", DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);

    // Start while busy must be ignored; exactly one done with the original operands.
    @(negedge clk);
    op = DIV; src_a = 32'hFFFF_FF9C; src_b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    for (int i = 1; i <= 45; i++) begin
      if (i == 5) begin
        op = DIVU; src_a = 32'd1000; src_b = 32'd10; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        pulses++;
        check("busy-start result", result, 32'hFFFF_FFF2);
      end
      @(negedge clk);
    end
    check("busy-start pulses", W'(pulses), W'(1));
    $display("busy-start         done pulses=%0d result=0x%08h", pulses, result);

    // Back-to-back: start held through the done cycle is accepted one cycle later.
    run("divu 50/5", DIVU, 32'd50, 32'd5, 32'd10);
    op = REMU; src_a = 32'd50; src_b = 32'd6; start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 2;
    while (!done && n < 45) begin
      @(negedge clk);
      n++;
    end
    check("b2b latency", W'(n), W'(34));
    check("b2b result", result, 32'd2);
    $display("back-to-back       remu 50/6 -> 0x%08h after %0d cycles", result, n);

    // Reset mid-operation clears outputs immediately and kills the done pulse.
    @(negedge clk);
    op = DIVU; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async busy", W'(busy), '0);
    check("async done", W'(done), '0);
    check("async result", result, '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("post-reset pulses", W'(pulses), '0);
    $display("reset mid-op       busy=%0d result=0x%08h later pulses=%0d", busy, result, pulses);
    run("divu 1000/3", DIVU, 32'd1000, 32'd3, 32'd333);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
